// File: rtl/sample_dma_pkg.sv
// Shared constants and state encoding for the AHB sample DMA master.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sample_dma_pkg;

  // AHB-Lite encodings used by the master
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/sample_sync_fifo.sv
// Single-clock sample FIFO with flush; first-word fall-through read port.
// Latency: a pushed word is visible on dout_o the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
// Ports: clk_i/rst_b_i (sync active-low), push_i/din_i, pop_i/dout_o,
//        flush_i (dominates push/pop), full_o/empty_o status.
module sample_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_b_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ahb_sample_dma_master.sv
// AHB-Lite write-only master streaming audio samples into a circular buffer.
// Latency: sample at cycle N -> NONSEQ address at N+1 -> data phase at N+2.
// Backpressure: source cannot stall; FIFO overflow drops samples (overrun).
// Ports: hclk/hrst_b (sync active-low); cfg_en/cfg_base/cfg_len config,
//        latched on cfg_en rising; smp_valid/smp_data sample input;
//        haddr/htrans/hwrite/hsize/hburst/hprot/hwdata/hready/hresp AHB-Lite;
//        wr_idx next buffer index; intr half/wrap pulse; overrun/bus_err sticky.
// Optional: SAMPLE_DMA_DROP_CNT_EN adds drop_cnt (saturating dropped-sample count).
module ahb_sample_dma_master
  import sample_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic             hclk,
  input  logic             hrst_b,
  input  logic             cfg_en,
  input  logic [31:0]      cfg_base,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             smp_valid,
  input  logic [31:0]      smp_data,
  output logic [31:0]      haddr,
  output logic [1:0]       htrans,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [2:0]       hburst,
  output logic [3:0]       hprot,
  output logic [31:0]      hwdata,
  input  logic             hready,
  input  logic [1:0]       hresp,
  output logic [LEN_W-1:0] wr_idx,
`ifdef SAMPLE_DMA_DROP_CNT_EN
  output logic [15:0]      drop_cnt,
`endif
  output logic             intr,
  output logic             overrun,
  output logic             bus_err
);

  dma_state_e       state_q, state_d;
  logic             en_q;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic             intr_q, intr_d;
  logic             overrun_q, overrun_d;
  logic             bus_err_q, bus_err_d;

  logic             en_rise;
  logic             enabled;
  logic             len_ok;
  logic             smp_avail;
  logic             drop;
  logic             fifo_pop;
  logic             fifo_flush;
  logic [31:0]      fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  sample_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (hclk),
    .rst_b_i (hrst_b),
    .push_i  (smp_valid),
    .din_i   (smp_data),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Config is only trusted one cycle after the rising edge that latched it;
  // a low cfg_en takes effect immediately.
  assign en_rise = cfg_en & ~en_q;
  assign enabled = cfg_en & en_q;
  assign len_ok  = (len_q >= LEN_W'(2));
  // A sample arriving this cycle lands in the FIFO at this edge, so it can
  // already launch the address phase (keeps sample-to-address at one cycle).
  assign smp_avail = ~fifo_empty | smp_valid;
  assign drop      = smp_valid & fifo_full & ~fifo_pop;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hwdata_d   = hwdata_q;
    intr_d     = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    overrun_d  = (en_rise ? 1'b0 : overrun_q) | drop;
    bus_err_d  = en_rise ? 1'b0 : bus_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!enabled) begin
          fifo_flush = 1'b1;
          idx_d      = '0;
        end else if (len_ok && smp_avail) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          fifo_pop = 1'b1;
          hwdata_d = fifo_dout;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        // ERROR is acted on in its first (hready=0) cycle.
        if (hresp == HRESP_ERROR) begin
          bus_err_d = 1'b1;
          state_d   = ST_ERR;
        end else if (hready) begin
          if (idx_q == len_q - LEN_W'(1)) idx_d = '0;
          else                             idx_d = idx_q + LEN_W'(1);
          if ((idx_q == len_q - LEN_W'(1)) ||
              (idx_q == (len_q >> 1) - LEN_W'(1))) begin
            intr_d = 1'b1;
          end
          if (!enabled) begin
            state_d    = ST_IDLE;
            fifo_flush = 1'b1;
            idx_d      = '0;
          end else if (smp_avail) begin
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        if (!cfg_en) begin
          state_d    = ST_IDLE;
          fifo_flush = 1'b1;
          idx_d      = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hrst_b) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      hwdata_q  <= '0;
      intr_q    <= 1'b0;
      overrun_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= cfg_en;
      idx_q     <= idx_d;
      hwdata_q  <= hwdata_d;
      intr_q    <= intr_d;
      overrun_q <= overrun_d;
      bus_err_q <= bus_err_d;
      if (en_rise) begin
        base_q <= cfg_base & 32'hFFFF_FFFC;
        len_q  <= cfg_len;
      end
    end
  end

`ifdef SAMPLE_DMA_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = en_rise ? 16'h0 : drop_cnt_q;
    if (drop && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'h1;
  end

  always_ff @(posedge hclk) begin
    if (!hrst_b) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // Address phase is driven straight from state; wraps modulo 2^32.
  assign htrans  = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite  = (state_q == ST_ADDR);
  assign haddr   = base_q + (32'(idx_q) << 2);
  assign hsize   = HSIZE_WORD;
  assign hburst  = HBURST_SINGLE;
  assign hprot   = HPROT_DATA;
  assign hwdata  = hwdata_q;
  assign wr_idx  = idx_q;
  assign intr    = intr_q;
  assign overrun = overrun_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_ahb_sample_dma_master.sv
module tb_ahb_sample_dma_master;

  localparam int LEN_W = 16;
  localparam logic [31:0] BASE = 32'h2000_0100;

  logic             hclk = 1'b0;
  logic             hrst_b;
  logic             cfg_en;
  logic [31:0]      cfg_base;
  logic [LEN_W-1:0] cfg_len;
  logic             smp_valid;
  logic [31:0]      smp_data;
  logic [31:0]      haddr;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [2:0]       hburst;
  logic [3:0]       hprot;
  logic [31:0]      hwdata;
  logic             hready;
  logic [1:0]       hresp;
  logic [LEN_W-1:0] wr_idx;
  logic             intr;
  logic             overrun;
  logic             bus_err;
`ifdef SAMPLE_DMA_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  ahb_sample_dma_master #(.FIFO_DEPTH(8), .LEN_W(LEN_W)) dut (
    .hclk      (hclk),
    .hrst_b    (hrst_b),
    .cfg_en    (cfg_en),
    .cfg_base  (cfg_base),
    .cfg_len   (cfg_len),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hprot     (hprot),
    .hwdata    (hwdata),
    .hready    (hready),
    .hresp     (hresp),
    .wr_idx    (wr_idx),
`ifdef SAMPLE_DMA_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .intr      (intr),
    .overrun   (overrun),
    .bus_err   (bus_err)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [15:0] idx_after;
    logic        intr;
  } vec_t;

  wr_t   sb_q[$];
  vec_t  tbl[4];
  int    checks = 0;
  int    errors = 0;
  int    wr_count = 0;
  int    intr_cnt = 0;
  logic  pend = 1'b0;
  logic [31:0] pend_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Drive one sample into an idle block and wait (bounded) for its write.
  task automatic do_write(input logic [31:0] d, input logic [31:0] a);
    int start;
    expect_write(a, d);
    start = wr_count;
    smp_data  = d;
    smp_valid = 1'b1;
    step();
    smp_valid = 1'b0;
    for (int k = 0; k < 20 && wr_count == start; k++) step();
    chk("write_done", 32'(wr_count - start), 32'd1);
  endtask

  // Bus monitor: completed OKAY data phases are popped from the scoreboard.
  always @(negedge hclk) begin
    if (hrst_b) begin
      if (pend && hready) begin
        pend = 1'b0;
        if (hresp == 2'b00) begin
          wr_count++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected none", pend_addr, hwdata);
          end else begin
            wr_t e;
            e = sb_q.pop_front();
            chk("wr_addr", pend_addr, e.addr);
            chk("wr_data", hwdata, e.data);
          end
        end
      end
      if (htrans == 2'b10 && hready) begin
        pend      = 1'b1;
        pend_addr = haddr;
        chk("hwrite", 32'(hwrite), 32'd1);
        chk("hsize_hburst_hprot", {22'd0, hsize, hburst, hprot}, {22'd0, 3'b010, 3'b000, 4'b0011});
      end
      if (intr) intr_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_wr;
    int start_intr;

    tbl[0] = '{32'hA0A0_0001, BASE + 32'h0, 16'd1, 1'b0};
    tbl[1] = '{32'hB0B0_0002, BASE + 32'h4, 16'd2, 1'b1};
    tbl[2] = '{32'hC0C0_0003, BASE + 32'h8, 16'd3, 1'b0};
    tbl[3] = '{32'hD0D0_0004, BASE + 32'hC, 16'd0, 1'b1};

    hrst_b = 1'b0; cfg_en = 1'b0; cfg_base = BASE; cfg_len = 16'd4;
    smp_valid = 1'b0; smp_data = '0; hready = 1'b1; hresp = 2'b00;
    repeat (3) step();

    // Reset state
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("rst_flags", {29'd0, intr, overrun, bus_err}, 32'd0);
    hrst_b = 1'b1;
    step();

    // Basic circular fill, table driven
    cfg_en = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      expect_write(tbl[i].addr, tbl[i].data);
      smp_data  = tbl[i].data;
      smp_valid = 1'b1;
      step();
      smp_valid = 1'b0;
      chk("t1_htrans_addr", 32'(htrans), 32'd2);
      chk("t1_haddr", haddr, tbl[i].addr);
      chk("t1_intr_low", 32'(intr), 32'd0);
      step();
      chk("t1_data_htrans", 32'(htrans), 32'd0);
      chk("t1_hwdata", hwdata, tbl[i].data);
      step();
      chk("t1_wr_idx", 32'(wr_idx), 32'(tbl[i].idx_after));
      chk("t1_intr", 32'(intr), 32'(tbl[i].intr));
    end

    // Wait states in address and data phases
    start_wr = wr_count;
    hready = 1'b0;
    expect_write(BASE, 32'hE0E0_0005);
    smp_data = 32'hE0E0_0005; smp_valid = 1'b1;
    step();
    smp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_addr_htrans", 32'(htrans), 32'd2);
      chk("t2_addr_haddr", haddr, BASE);
      step();
    end
    hready = 1'b1;
    step();
    hready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("t2_data_hwdata", hwdata, 32'hE0E0_0005);
      chk("t2_data_htrans", 32'(htrans), 32'd0);
      step();
    end
    hready = 1'b1;
    step();
    chk("t2_one_write", 32'(wr_count - start_wr), 32'd1);
    chk("t2_wr_idx", 32'(wr_idx), 32'd1);

    // Overrun: 12 samples into an 8-deep FIFO while the bus is stalled
    start_wr = wr_count;
    start_intr = intr_cnt;
    hready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) expect_write(BASE + 32'(((1 + i) % 4) * 4), 32'hC000_0000 + 32'(i));
      smp_data  = 32'hC000_0000 + 32'(i);
      smp_valid = 1'b1;
      step();
    end
    smp_valid = 1'b0;
    chk("t3_overrun", 32'(overrun), 32'd1);
`ifdef SAMPLE_DMA_DROP_CNT_EN
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd4);
`endif
    hready = 1'b1;
    for (int k = 0; k < 60 && (wr_count - start_wr) < 8; k++) step();
    chk("t3_write_count", 32'(wr_count - start_wr), 32'd8);
    step();
    step();
    chk("t3_wr_idx", 32'(wr_idx), 32'd1);
    chk("t3_intr_count", 32'(intr_cnt - start_intr), 32'd4);
    chk("t3_idle", 32'(htrans), 32'd0);

    // Re-enable clears sticky flags
    cfg_en = 1'b0;
    step();
    step();
    chk("t4_idx_on_disable", 32'(wr_idx), 32'd0);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);
    cfg_en = 1'b1;
    step();
    step();
    chk("t4_overrun_clr", 32'(overrun), 32'd0);
`ifdef SAMPLE_DMA_DROP_CNT_EN
    chk("t4_drop_cnt_clr", 32'(drop_cnt), 32'd0);
`endif

    // ERROR response on the second write
    do_write(32'h1111_0001, BASE);
    smp_data = 32'h1111_0002; smp_valid = 1'b1;
    step();
    smp_valid = 1'b0;
    chk("t4_err_addr", haddr, BASE + 32'h4);
    step();
    hresp = 2'b01; hready = 1'b0;
    step();
    hready = 1'b1;
    step();
    hresp = 2'b00;
    chk("t4_bus_err", 32'(bus_err), 32'd1);
    start_wr = wr_count;
    smp_data = 32'h1111_0003; smp_valid = 1'b1;
    step();
    smp_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t4_err_no_nonseq", 32'(htrans), 32'd0);
      step();
    end
    chk("t4_err_no_write", 32'(wr_count - start_wr), 32'd0);
    cfg_en = 1'b0;
    step();
    step();
    cfg_en = 1'b1;
    step();
    step();
    chk("t4_bus_err_clr", 32'(bus_err), 32'd0);
    chk("t4_restart_idx", 32'(wr_idx), 32'd0);
    do_write(32'h1111_0004, BASE);

    // cfg_en drops during the data phase of index 2
    do_write(32'h2222_0005, BASE + 32'h4);
    start_wr = wr_count;
    expect_write(BASE + 32'h8, 32'h2222_0006);
    smp_data = 32'h2222_0006; smp_valid = 1'b1;
    step();
    smp_data = 32'h2222_0007;
    step();
    smp_valid = 1'b0;
    cfg_en = 1'b0;
    chk("t5_hwdata", hwdata, 32'h2222_0006);
    step();
    chk("t5_completed", 32'(wr_count - start_wr), 32'd1);
    chk("t5_wr_idx", 32'(wr_idx), 32'd0);
    chk("t5_htrans", 32'(htrans), 32'd0);
    cfg_en = 1'b1;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t5_flushed_idle", 32'(htrans), 32'd0);
      step();
    end
    chk("t5_no_extra_write", 32'(wr_count - start_wr), 32'd1);

    // cfg_len < 2 keeps the block idle
    cfg_en = 1'b0; cfg_len = 16'd1;
    step();
    cfg_en = 1'b1;
    step();
    step();
    start_intr = intr_cnt;
    for (int k = 0; k < 8; k++) begin
      smp_data  = 32'h3333_0000 + 32'(k);
      smp_valid = (k % 2 == 0);
      step();
      chk("t6_idle", 32'(htrans), 32'd0);
    end
    smp_valid = 1'b0;
    step();
    chk("t6_no_intr", 32'(intr_cnt - start_intr), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
